// File: rtl/aead_if.sv
// Request, stream and tag handshake signals of the AEAD encryptor.
// The master drives requests and data in; the slave (the encryptor) answers.
interface aead_if;
  logic        start;
  logic [31:0] key;
  logic [31:0] nonce;
  logic        has_ad;
  logic        has_pt;
  logic        ad_valid;
  logic        ad_ready;
  logic [31:0] ad_data;
  logic        ad_last;
  logic        pt_valid;
  logic        pt_ready;
  logic [31:0] pt_data;
  logic        pt_last;
  logic        ct_valid;
  logic        ct_ready;
  logic [31:0] ct_data;
  logic        tag_valid;
  logic        tag_ready;
  logic [31:0] tag;
  logic        busy;

  modport master (
    output start, key, nonce, has_ad, has_pt,
    output ad_valid, ad_data, ad_last,
    output pt_valid, pt_data, pt_last,
    output ct_ready, tag_ready,
    input  ad_ready, pt_ready, ct_valid, ct_data, tag_valid, tag, busy
  );

  modport slave (
    input  start, key, nonce, has_ad, has_pt,
    input  ad_valid, ad_data, ad_last,
    input  pt_valid, pt_data, pt_last,
    input  ct_ready, tag_ready,
    output ad_ready, pt_ready, ct_valid, ct_data, tag_valid, tag, busy
  );
endinterface

// File: rtl/aead_encrypt.sv
// Toy sponge-style AEAD encryptor: 64-bit state (rate X, capacity Y),
// 8-round permutation run one round per clock between absorb/squeeze steps.
module aead_encrypt (
  input  logic   clk,
  input  logic   reset,
  aead_if.slave  bus
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_INIT_PERM = 4'd1;
  localparam logic [3:0] S_AD_WAIT   = 4'd2;
  localparam logic [3:0] S_AD_PERM   = 4'd3;
  localparam logic [3:0] S_MSG_WAIT  = 4'd4;
  localparam logic [3:0] S_CT_OUT    = 4'd5;
  localparam logic [3:0] S_MSG_PERM  = 4'd6;
  localparam logic [3:0] S_FIN_PERM  = 4'd7;
  localparam logic [3:0] S_TAG_OUT   = 4'd8;

  logic [3:0]  r_state;
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic [31:0] r_key;
  logic [31:0] r_ct;
  logic [31:0] r_tag;
  logic [2:0]  r_cnt;
  logic        r_has_ad;
  logic        r_has_pt;
  logic        r_ad_last;
  logic        r_pt_last;

  logic [31:0] w_rx;
  logic [31:0] w_ry;
  logic        w_last_rnd;

  // One round R(i); the round constant i+1 needs 4 bits since i reaches 7.
  function automatic logic [63:0] round_fn(input logic [31:0] x,
                                           input logic [31:0] y,
                                           input logic [2:0]  i);
    logic [31:0] rot;
    logic [3:0]  rc;
    rot = {x[26:0], x[31:27]};
    rc  = {1'b0, i} + 4'd1;
    return {y ^ rot ^ {28'd0, rc}, x + y};
  endfunction

  assign {w_rx, w_ry} = round_fn(r_x, r_y, r_cnt);
  assign w_last_rnd   = (r_cnt == 3'd7);

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.ad_ready  = (r_state == S_AD_WAIT);
  assign bus.pt_ready  = (r_state == S_MSG_WAIT);
  assign bus.ct_valid  = (r_state == S_CT_OUT);
  assign bus.tag_valid = (r_state == S_TAG_OUT);
  assign bus.ct_data   = r_ct;
  assign bus.tag       = r_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_key     <= '0;
      r_ct      <= '0;
      r_tag     <= '0;
      r_cnt     <= '0;
      r_has_ad  <= 1'b0;
      r_has_pt  <= 1'b0;
      r_ad_last <= 1'b0;
      r_pt_last <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_x      <= bus.key;
            r_y      <= bus.nonce;
            r_key    <= bus.key;
            r_has_ad <= bus.has_ad;
            r_has_pt <= bus.has_pt;
            r_cnt    <= '0;
            r_state  <= S_INIT_PERM;
          end
        end
        S_INIT_PERM: begin
          r_x   <= w_rx;
          r_y   <= w_ry;
          r_cnt <= r_cnt + 3'd1;
          if (w_last_rnd) begin
            r_cnt <= '0;
            if (r_has_ad) begin
              r_state <= S_AD_WAIT;
            end else if (r_has_pt) begin
              r_y     <= w_ry ^ 32'd1;
              r_state <= S_MSG_WAIT;
            end else begin
              // Empty AD and empty message: both domain separators at once.
              r_y     <= w_ry ^ 32'd3;
              r_state <= S_FIN_PERM;
            end
          end
        end
        S_AD_WAIT: begin
          if (bus.ad_valid) begin
            r_x       <= r_x ^ bus.ad_data;
            r_ad_last <= bus.ad_last;
            r_state   <= S_AD_PERM;
          end
        end
        S_AD_PERM: begin
          r_x   <= w_rx;
          r_y   <= w_ry;
          r_cnt <= r_cnt + 3'd1;
          if (w_last_rnd) begin
            r_cnt <= '0;
            if (!r_ad_last) begin
              r_state <= S_AD_WAIT;
            end else if (r_has_pt) begin
              r_y     <= w_ry ^ 32'd1;
              r_state <= S_MSG_WAIT;
            end else begin
              r_y     <= w_ry ^ 32'd3;
              r_state <= S_FIN_PERM;
            end
          end
        end
        S_MSG_WAIT: begin
          if (bus.pt_valid) begin
            r_ct      <= r_x ^ bus.pt_data;
            r_x       <= r_x ^ bus.pt_data;
            r_pt_last <= bus.pt_last;
            r_state   <= S_CT_OUT;
          end
        end
        S_CT_OUT: begin
          if (bus.ct_ready) r_state <= S_MSG_PERM;
        end
        S_MSG_PERM: begin
          r_x   <= w_rx;
          r_y   <= w_ry;
          r_cnt <= r_cnt + 3'd1;
          if (w_last_rnd) begin
            r_cnt <= '0;
            if (!r_pt_last) begin
              r_state <= S_MSG_WAIT;
            end else begin
              r_y     <= w_ry ^ 32'd2;
              r_state <= S_FIN_PERM;
            end
          end
        end
        S_FIN_PERM: begin
          r_x   <= w_rx;
          r_y   <= w_ry;
          r_cnt <= r_cnt + 3'd1;
          if (w_last_rnd) begin
            r_cnt   <= '0;
            r_tag   <= w_rx ^ r_key;
            r_state <= S_TAG_OUT;
          end
        end
        S_TAG_OUT: begin
          if (bus.tag_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aead_encrypt.sv
// Scoreboard bench for aead_encrypt: an algorithmic model queues expected
// ciphertext words and tags, which are popped as the DUT presents them.
module tb_aead_encrypt;

  logic clk = 1'b0;
  logic reset;
  aead_if bus ();

  aead_encrypt dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int ad_acc = 0;
  int pt_acc = 0;

  logic [31:0] exp_q[$];
  logic [31:0] ad_w[4];
  logic [31:0] pt_w[4];
  int          n_ad;
  int          n_pt;
  logic [31:0] tag_full;
  logic [31:0] tag_tmp;
  int          lat;

  always @(posedge clk) begin
    if (bus.ad_valid && bus.ad_ready) ad_acc <= ad_acc + 1;
    if (bus.pt_valid && bus.pt_ready) pt_acc <= pt_acc + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return bus.ad_ready;
      1:       return bus.pt_ready;
      2:       return bus.ct_valid;
      default: return bus.tag_valid;
    endcase
  endfunction

  task automatic wait_sig(input int w, input string name, output int n);
    n = 0;
    while (sig(w) !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk({name, "_timeout"}, 32'(n), 32'd0);
  endtask

  function automatic logic [63:0] perm_m(input logic [63:0] s);
    logic [31:0] x, y, t;
    x = s[63:32];
    y = s[31:0];
    for (int i = 0; i < 8; i++) begin
      t = y ^ ((x << 5) | (x >> 27)) ^ 32'(i + 1);
      y = x + y;
      x = t;
    end
    return {x, y};
  endfunction

  task automatic pop_chk(input string name, input logic [31:0] got);
    if (exp_q.size() == 0) chk({name, "_q_empty"}, 32'd1, 32'd0);
    else chk(name, got, exp_q.pop_front());
  endtask

  task automatic chk_idle_outputs(input string pfx);
    chk({pfx, "_busy"},      32'(bus.busy),      32'd0);
    chk({pfx, "_ad_ready"},  32'(bus.ad_ready),  32'd0);
    chk({pfx, "_pt_ready"},  32'(bus.pt_ready),  32'd0);
    chk({pfx, "_ct_valid"},  32'(bus.ct_valid),  32'd0);
    chk({pfx, "_tag_valid"}, 32'(bus.tag_valid), 32'd0);
    chk({pfx, "_ct_data"},   bus.ct_data,        32'd0);
    chk({pfx, "_tag"},       bus.tag,            32'd0);
  endtask

  task automatic run_op(input logic [31:0] key, input logic [31:0] nonce,
                        input logic had, input logic hpt,
                        input int stall_beat, input int stall_n, input bit spur,
                        output logic [31:0] tag_out, output int tag_lat);
    logic [63:0] s;
    logic [31:0] c;
    int n, a0, p0;
    s = perm_m({key, nonce});
    if (had) begin
      for (int i = 0; i < n_ad; i++) begin
        s[63:32] ^= ad_w[i];
        s = perm_m(s);
      end
    end
    s[31:0] ^= 32'd1;
    if (hpt) begin
      for (int i = 0; i < n_pt; i++) begin
        c = s[63:32] ^ pt_w[i];
        exp_q.push_back(c);
        s[63:32] = c;
        s = perm_m(s);
      end
    end
    s[31:0] ^= 32'd2;
    s = perm_m(s);
    exp_q.push_back(s[63:32] ^ key);

    a0 = ad_acc;
    p0 = pt_acc;
    bus.key = key; bus.nonce = nonce; bus.has_ad = had; bus.has_pt = hpt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);

    if (had) begin
      for (int i = 0; i < n_ad; i++) begin
        bus.ad_valid = 1'b1; bus.ad_data = ad_w[i]; bus.ad_last = (i == n_ad - 1);
        wait_sig(0, "ad_ready", n);
        tick();
        bus.ad_valid = 1'b0; bus.ad_last = 1'b0;
      end
    end
    if (hpt) begin
      for (int i = 0; i < n_pt; i++) begin
        if (spur) begin
          bus.ad_valid = 1'b1; bus.ad_data = 32'h5A5A0F0F; bus.ad_last = 1'b1;
        end
        bus.pt_valid = 1'b1; bus.pt_data = pt_w[i]; bus.pt_last = (i == n_pt - 1);
        wait_sig(1, "pt_ready", n);
        if (spur) chk("spur_ad_ready", 32'(bus.ad_ready), 32'd0);
        tick();
        bus.pt_valid = 1'b0; bus.pt_last = 1'b0; bus.ad_valid = 1'b0; bus.ad_last = 1'b0;
        wait_sig(2, "ct_valid", n);
        if (i == stall_beat) begin
          c = bus.ct_data;
          for (int k = 0; k < stall_n; k++) begin
            tick();
            chk("stall_ct_valid", 32'(bus.ct_valid), 32'd1);
            chk("stall_ct_data",  bus.ct_data,       c);
            chk("stall_pt_ready", 32'(bus.pt_ready), 32'd0);
          end
        end
        pop_chk("ct", bus.ct_data);
        bus.ct_ready = 1'b1;
        tick();
        bus.ct_ready = 1'b0;
        if (spur) begin
          bus.start = 1'b1;
          tick();
          tick();
          bus.start = 1'b0;
          chk("spur_busy", 32'(bus.busy), 32'd1);
        end
      end
    end
    wait_sig(3, "tag_valid", tag_lat);
    tag_out = bus.tag;
    pop_chk("tag", bus.tag);
    bus.tag_ready = 1'b1;
    tick();
    bus.tag_ready = 1'b0;
    chk("busy_after_tag", 32'(bus.busy), 32'd0);
    chk("ad_accepts", 32'(ad_acc - a0), had ? 32'(n_ad) : 32'd0);
    chk("pt_accepts", 32'(pt_acc - p0), hpt ? 32'(n_pt) : 32'd0);
  endtask

  task automatic load_full();
    n_ad = 2; ad_w[0] = 32'hDEADBEEF; ad_w[1] = 32'h00000001;
    n_pt = 3; pt_w[0] = 32'h00000000; pt_w[1] = 32'hFFFFFFFF; pt_w[2] = 32'hA5A5A5A5;
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.key = '0; bus.nonce = '0; bus.has_ad = 1'b0; bus.has_pt = 1'b0;
    bus.ad_valid = 1'b0; bus.ad_data = '0; bus.ad_last = 1'b0;
    bus.pt_valid = 1'b0; bus.pt_data = '0; bus.pt_last = 1'b0;
    bus.ct_ready = 1'b0; bus.tag_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk_idle_outputs("rst");
    reset = 1'b0;
    tick();

    // Bare operation: no AD, no PT.
    n_ad = 0; n_pt = 0;
    run_op(32'h01234567, 32'h89ABCDEF, 1'b0, 1'b0, -1, 0, 1'b0, tag_tmp, lat);
    chk("bare_tag_latency", 32'(lat), 32'd16);

    // Full operation, then the same with a stalled second CT beat.
    load_full();
    run_op(32'h01234567, 32'h89ABCDEF, 1'b1, 1'b1, -1, 0, 1'b0, tag_full, lat);
    run_op(32'h01234567, 32'h89ABCDEF, 1'b1, 1'b1, 1, 20, 1'b0, tag_tmp, lat);
    chk("stall_tag_same", tag_tmp, tag_full);

    // Reset at round 4 of the first AD permutation.
    bus.key = 32'h01234567; bus.nonce = 32'h89ABCDEF; bus.has_ad = 1'b1; bus.has_pt = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.ad_valid = 1'b1; bus.ad_data = 32'hDEADBEEF; bus.ad_last = 1'b0;
    wait_sig(0, "abort_ad_ready", n);
    tick();
    bus.ad_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk_idle_outputs("abort");
    #2;
    reset = 1'b0;
    tick();
    load_full();
    run_op(32'h01234567, 32'h89ABCDEF, 1'b1, 1'b1, -1, 0, 1'b0, tag_tmp, lat);
    chk("after_abort_tag_same", tag_tmp, tag_full);

    // Spurious start during MSG_PERM and ad_valid during MSG_WAIT.
    run_op(32'h01234567, 32'h89ABCDEF, 1'b1, 1'b1, -1, 0, 1'b1, tag_tmp, lat);
    chk("spur_tag_same", tag_tmp, tag_full);

    // Single-word AD and PT phases.
    n_ad = 1; ad_w[0] = 32'hCAFEF00D;
    n_pt = 1; pt_w[0] = 32'h12345678;
    run_op(32'h0F1E2D3C, 32'h4B5A6978, 1'b1, 1'b1, -1, 0, 1'b0, tag_tmp, lat);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aead_encrypt.md
AEAD_ENCRYPT -- requirements
Module: aead_encrypt

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- key  in  32  secret key; captured when start is accepted
- nonce  in  32  nonce; captured when start is accepted
- has_ad  in  1  1 = associated-data phase present; captured at start
- has_pt  in  1  1 = plaintext phase present; captured at start
- ad_valid / ad_ready / ad_data[31:0] / ad_last  in / out / in / in  associated-data stream
- pt_valid / pt_ready / pt_data[31:0] / pt_last  in / out / in / in  plaintext stream
- ct_valid / ct_ready / ct_data[31:0]  out / in / out  ciphertext stream
- tag_valid / tag_ready / tag[31:0]  out / in / out  authentication tag
- busy  out  1  high in every state except IDLE

REQ-002 All handshakes SHALL be valid/ready: a transfer occurs on a rising edge where both are high.

REQ-003 The block SHALL have no parameters; the state is fixed at 64 bits: rate X[31:0] and capacity Y[31:0].

Function
REQ-004 Round function R(i), i = 0..7, SHALL compute:
- X' = Y ^ rotl(X, 5) ^ (i+1), with the constant zero-extended to 32 bits
- Y' = (X + Y) mod 2^32

REQ-005 Permutation P SHALL be R(0)..R(7), one round per clock, counted by a 3-bit round counter.

REQ-006 States SHALL be IDLE, INIT_PERM, AD_WAIT, AD_PERM, MSG_WAIT, CT_OUT, MSG_PERM, FIN_PERM and TAG_OUT.

REQ-007 IDLE, on start=1: X<=key, Y<=nonce, latch has_ad/has_pt/key, counter<=0, go to INIT_PERM.

REQ-008 Any *_PERM state SHALL apply one round per edge and leave on the edge applying R(7), which also clears the counter.

REQ-009 Leaving INIT_PERM:
- has_ad=1: go to AD_WAIT.
- has_ad=0: Y^=1 after the round, then go to MSG_WAIT if has_pt=1.
- has_ad=0, has_pt=0: additionally Y^=2, then go to FIN_PERM.

REQ-010 AD_WAIT SHALL hold ad_ready=1. On an AD transfer: X^=ad_data, remember ad_last, go to AD_PERM.

REQ-011 Leaving AD_PERM:
- ad_last was 0: return to AD_WAIT.
- ad_last was 1: Y^=1, then go to MSG_WAIT if has_pt=1, else Y^=2 and go to FIN_PERM.

REQ-012 MSG_WAIT SHALL hold pt_ready=1. On a PT transfer:
- ct_data<=X^pt_data and X<=X^pt_data on the same edge;
- remember pt_last;
- go to CT_OUT.

REQ-013 CT_OUT SHALL hold ct_valid=1 with ct_data stable until ct_ready=1; on that transfer go to MSG_PERM.

REQ-014 Leaving MSG_PERM: pt_last was 0 → return to MSG_WAIT; pt_last was 1 → Y^=2, go to FIN_PERM.

REQ-015 Leaving FIN_PERM: register tag<=X'^latched key (X' is the R(7) output), go to TAG_OUT.

REQ-016 TAG_OUT SHALL hold tag_valid=1 with tag stable; on tag_ready=1 return to IDLE.

REQ-017 The ready and valid outputs SHALL be Moore outputs, high only in their named states, with no combinational path from any input.

REQ-018 start outside IDLE SHALL be ignored; ad_valid/pt_valid outside their wait states SHALL be ignored and never accepted.

REQ-019 A zero-length stream is expressed only through has_ad=0 or has_pt=0; the *_last inputs SHALL be honoured only on transfer beats.

REQ-020 Latency SHALL be:
- start to first ready or FIN_PERM entry: 8 cycles;
- each AD or PT word: 1 accept cycle + 8 permutation cycles, plus CT stall cycles for PT words.

Reset
REQ-021 Asserting reset SHALL immediately force, in any state including mid-permutation:
- state=IDLE, X=Y=0, counter=0, latched flags=0;
- ct_data=tag=0;
- busy, ad_ready, pt_ready, ct_valid, tag_valid all 0.

REQ-022 After reset deasserts, the first rising edge with start=1 SHALL begin a new operation; no state from the aborted operation survives.

Verification
REQ-023 Bare operation: key=32'h01234567, nonce=32'h89ABCDEF, has_ad=0, has_pt=0, start pulse → busy next cycle; tag_valid high 16 edges after the start edge; tag equals the golden model; tag_ready=1 → IDLE, busy=0.

REQ-024 Full operation: 2 AD words (32'hDEADBEEF, 32'h00000001 with ad_last) and 3 PT words (32'h0, 32'hFFFFFFFF, 32'hA5A5A5A5 with pt_last) → 3 CT beats and a tag, all equal to the golden model. With pt_data=0, ct_data equals the model rate word.

REQ-025 Backpressure: ct_ready held 0 for 20 cycles on the second CT beat → ct_valid and ct_data stable, pt_ready=0 throughout; the final tag is identical to the no-stall run.

REQ-026 Reset mid-operation: reset at round 4 of AD_PERM → all outputs 0 the same cycle; a subsequent full run with the same inputs matches REQ-024 exactly.

REQ-027 Spurious inputs: start pulsed during MSG_PERM, and ad_valid=1 during MSG_WAIT → neither accepted, ad_ready stays 0, outputs unchanged versus a clean run.

REQ-028 Single-word phases: has_ad=1 with one word carrying ad_last=1, has_pt=1 with one word carrying pt_last=1 → exactly 1 ad_ready and 1 pt_ready acceptance; tag matches the golden model.
